p405s_dcr_access_ctl: RTL and testbench

- Sequences Device Control Register (DCR) bus transactions for mfdcr/mtdcr issued by the EXE stage.
- Takes the DCR address and data buses produced by the EXE SPR/DCR fan-out logic and drives the external DCR read/write strobes.
- Runs the 4-phase acknowledge handshake, applies a timeout, and stalls the pipeline until the access completes.
- Sits between the EXE stage and the chip-level DCR daisy-chain.

---
 rtl/p405s_dcr_pkg.sv | 19 +
 rtl/p405s_dcr_sync2.sv | 33 +++
 rtl/p405s_dcr_access_ctl.sv | 185 ++++++++++++++++++
 tb/tb_p405s_dcr_access_ctl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/p405s_dcr_pkg.sv
// Shared types and constants for the DCR access controller.
package p405s_dcr_pkg;

    localparam int unsigned DCR_ABUS_W = 10;
    localparam int unsigned DCR_DBUS_W = 32;

    // FSM encoding kept as plain constants for legacy tool compatibility
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_XFER    = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

    // Request payload as presented by the EXE fan-out
    typedef struct packed {
        logic [0:DCR_ABUS_W-1] addr;
        logic [0:DCR_DBUS_W-1] data;
    } dcr_req_t;

endpackage : p405s_dcr_pkg

// File: rtl/p405s_dcr_sync2.sv
// Two-flop synchronizer for the external DCR acknowledge.
module p405s_dcr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Shift chain next values
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : p405s_dcr_sync2

// File: rtl/p405s_dcr_access_ctl.sv
// DCR access controller: sequences mfdcr/mtdcr onto the DCR bus with a
// 4-phase acknowledge, timeout abort and pipeline stall.
// Optional build macro P405_DCR_ACK_SYNC_EN adds a 2-flop ack synchronizer.
module p405s_dcr_access_ctl
    import p405s_dcr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic                  CB,
    input  logic                  resetCore,
    input  logic                  exeDcrRdReq,
    input  logic                  exeDcrWrReq,
    input  logic [0:DCR_ABUS_W-1] EXE_dcrAddr,
    input  logic [0:DCR_DBUS_W-1] EXE_dcrDataBus,
    input  logic                  DCR_cpuAck,
    input  logic [0:DCR_DBUS_W-1] DCR_cpuDBusIn,
    output logic                  CPU_dcrRead,
    output logic                  CPU_dcrWrite,
    output logic [0:DCR_ABUS_W-1] CPU_dcrABus,
    output logic [0:DCR_DBUS_W-1] CPU_dcrDBusOut,
    output logic                  dcrHold,
    output logic                  dcrDone,
    output logic [0:DCR_DBUS_W-1] dcrRdData,
    output logic                  dcrTimeout,
    output logic                  dcrErr
);

    localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0
                                          : CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  rd_q,       rd_d;
    logic                  wr_q,       wr_d;
    logic [0:DCR_ABUS_W-1] abus_q,     abus_d;
    logic [0:DCR_DBUS_W-1] dbus_q,     dbus_d;
    logic [0:DCR_DBUS_W-1] rdata_q,    rdata_d;
    logic                  tmo_flag_q, tmo_flag_d;
    logic                  done_q,     done_d;
    logic                  tmo_q,      tmo_d;
    logic                  err_q,      err_d;

    logic                  ack_s;
    logic                  dcr_hold_c;
    dcr_req_t              req_c;

`ifdef P405_DCR_ACK_SYNC_EN
    // Ack crosses from the DCR chain clock domain
    p405s_dcr_sync2 u_ack_sync (
        .clk (CB),
        .rst (resetCore),
        .d   (DCR_cpuAck),
        .q   (ack_s)
    );
`else
    assign ack_s = DCR_cpuAck;
`endif

    assign req_c = '{addr: EXE_dcrAddr, data: EXE_dcrDataBus};

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        abus_d     = abus_q;
        dbus_d     = dbus_q;
        rdata_d    = rdata_q;
        tmo_flag_d = tmo_flag_q;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (exeDcrRdReq && exeDcrWrReq) begin
                    // Illegal combined request: report without touching the bus
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (exeDcrRdReq || exeDcrWrReq) begin
                    abus_d = req_c.addr;
                    if (exeDcrWrReq) begin
                        dbus_d = req_c.data;
                    end
                    rd_d    = exeDcrRdReq;
                    wr_d    = exeDcrWrReq;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (ack_s) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (rd_q) begin
                        rdata_d = DCR_cpuDBusIn;
                    end
                    state_d = ST_RELEASE;
                end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    tmo_flag_d = 1'b1;
                    rdata_d    = '0;
                    state_d    = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                // Also absorbs a late ack after a timeout; no timeout here
                if (!ack_s) begin
                    done_d  = 1'b1;
                    tmo_d   = tmo_flag_q;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                tmo_flag_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CB) begin
        if (resetCore) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            abus_q     <= '0;
            dbus_q     <= '0;
            rdata_q    <= '0;
            tmo_flag_q <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            abus_q     <= abus_d;
            dbus_q     <= dbus_d;
            rdata_q    <= rdata_d;
            tmo_flag_q <= tmo_flag_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    // Stall: follows the raw request in IDLE, held while the bus is busy
    always_comb begin
        dcr_hold_c = 1'b0;
        case (state_q)
            ST_IDLE:    dcr_hold_c = exeDcrRdReq | exeDcrWrReq;
            ST_XFER:    dcr_hold_c = 1'b1;
            ST_RELEASE: dcr_hold_c = 1'b1;
            default:    dcr_hold_c = 1'b0;
        endcase
    end

    assign CPU_dcrRead    = rd_q;
    assign CPU_dcrWrite   = wr_q;
    assign CPU_dcrABus    = abus_q;
    assign CPU_dcrDBusOut = dbus_q;
    assign dcrHold        = dcr_hold_c;
    assign dcrDone        = done_q;
    assign dcrRdData      = rdata_q;
    assign dcrTimeout     = tmo_q;
    assign dcrErr         = err_q;

endmodule : p405s_dcr_access_ctl

// File: tb/tb_p405s_dcr_access_ctl.sv
// Scoreboard bench for p405s_dcr_access_ctl (timeout set to 8 cycles).
module tb_p405s_dcr_access_ctl;

    localparam int T_CYC = 8;
    localparam int WIN   = 24;
`ifdef P405_DCR_ACK_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        CB;
    logic        resetCore;
    logic        exeDcrRdReq;
    logic        exeDcrWrReq;
    logic [0:9]  EXE_dcrAddr;
    logic [0:31] EXE_dcrDataBus;
    logic        DCR_cpuAck;
    logic [0:31] DCR_cpuDBusIn;
    logic        CPU_dcrRead;
    logic        CPU_dcrWrite;
    logic [0:9]  CPU_dcrABus;
    logic [0:31] CPU_dcrDBusOut;
    logic        dcrHold;
    logic        dcrDone;
    logic [0:31] dcrRdData;
    logic        dcrTimeout;
    logic        dcrErr;

    p405s_dcr_access_ctl #(.TIMEOUT_CYC(T_CYC), .CNT_W(4)) dut (
        .CB             (CB),
        .resetCore      (resetCore),
        .exeDcrRdReq    (exeDcrRdReq),
        .exeDcrWrReq    (exeDcrWrReq),
        .EXE_dcrAddr    (EXE_dcrAddr),
        .EXE_dcrDataBus (EXE_dcrDataBus),
        .DCR_cpuAck     (DCR_cpuAck),
        .DCR_cpuDBusIn  (DCR_cpuDBusIn),
        .CPU_dcrRead    (CPU_dcrRead),
        .CPU_dcrWrite   (CPU_dcrWrite),
        .CPU_dcrABus    (CPU_dcrABus),
        .CPU_dcrDBusOut (CPU_dcrDBusOut),
        .dcrHold        (dcrHold),
        .dcrDone        (dcrDone),
        .dcrRdData      (dcrRdData),
        .dcrTimeout     (dcrTimeout),
        .dcrErr         (dcrErr)
    );

    typedef struct {
        int          done_cyc;
        logic [31:0] rdata;
        logic        tmo;
        logic        err;
        int          rd_len;
        int          wr_len;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_dbus  = '0;
    logic [9:0]  exp_abus  = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        CB = 1'b0;
        forever #5 CB = ~CB;
    end

    initial forever begin
        @(posedge CB);
        cyc++;
    end

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    // Completion monitor: pops the scoreboard on every dcrDone
    initial begin
        int   rd_cnt = 0;
        int   wr_cnt = 0;
        exp_t e;
        forever begin
            @(negedge CB);
            if (resetCore) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (CPU_dcrRead)  rd_cnt++;
                if (CPU_dcrWrite) wr_cnt++;
                if (dcrDone) begin
                    if (sb.size() == 0) begin
                        check_eq("done_spurious", 32'(dcrDone), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("done_cyc", 32'(cyc),        32'(e.done_cyc));
                        check_eq("rddata",   dcrRdData,       e.rdata);
                        check_eq("timeout",  32'(dcrTimeout), 32'(e.tmo));
                        check_eq("err",      32'(dcrErr),     32'(e.err));
                        check_eq("rd_len",   32'(rd_cnt),     32'(e.rd_len));
                        check_eq("wr_len",   32'(wr_cnt),     32'(e.wr_len));
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    // One access: model the expected timeline, push it, then drive ack per cycle
    task automatic do_access(input bit rd, input bit wr, input logic [9:0] addr,
                             input logic [31:0] data, input logic [31:0] ext,
                             input bit has_ack, input int ack_dly, input int ack_len);
        exp_t e;
        int   a, e_end, slen, r, hold_bad;
        bit   tmo, done_seen;
        hold_bad  = 0;
        done_seen = 0;
        tmo       = 0;
        if (rd && wr) begin
            slen = 0;
            r    = -1;
        end else begin
            a     = ack_dly + SYNC_LAT;
            e_end = a + ack_len;
            if (!has_ack || a >= T_CYC) begin
                tmo  = 1;
                slen = T_CYC;
            end else begin
                slen = a + 1;
            end
            r = (has_ack && a <= slen && slen < e_end) ? e_end : slen;
        end

        exeDcrRdReq    = rd;
        exeDcrWrReq    = wr;
        EXE_dcrAddr    = addr;
        EXE_dcrDataBus = data;
        DCR_cpuDBusIn  = ext;

        e.done_cyc = cyc + 2 + r;
        e.err      = rd && wr;
        e.tmo      = tmo;
        e.rd_len   = (rd && !wr) ? slen : 0;
        e.wr_len   = (wr && !rd) ? slen : 0;
        if (!(rd && wr)) begin
            if (tmo)     exp_rdata = '0;
            else if (rd) exp_rdata = ext;
            exp_abus = addr;
            if (wr) exp_dbus = data;
        end
        e.rdata = exp_rdata;
        sb.push_back(e);

        #1;
        check_eq("hold_req", 32'(dcrHold), 32'd1);
        for (int k = 0; k < WIN; k++) begin
            tick();
            if (k == 0 && !(rd && wr)) begin
                check_eq("strobe_rd", 32'(CPU_dcrRead),  32'(rd));
                check_eq("strobe_wr", 32'(CPU_dcrWrite), 32'(wr));
                check_eq("abus",      32'(CPU_dcrABus),  32'(exp_abus));
                check_eq("dbus",      CPU_dcrDBusOut,    exp_dbus);
            end
            DCR_cpuAck = has_ack && (k >= ack_dly) && (k < ack_dly + ack_len);
            if (dcrDone) begin
                exeDcrRdReq = 1'b0;
                exeDcrWrReq = 1'b0;
                done_seen   = 1'b1;
            end
            #1;
            if (dcrHold !== (k <= r)) hold_bad++;
        end
        DCR_cpuAck    = 1'b0;
        exeDcrRdReq   = 1'b0;
        exeDcrWrReq   = 1'b0;
        DCR_cpuDBusIn = 32'hBAD0_BAD0;
        check_eq("done_seen", 32'(done_seen),   32'd1);
        check_eq("hold_seq",  32'(hold_bad),    32'd0);
        check_eq("abus_keep", 32'(CPU_dcrABus), 32'(exp_abus));
        check_eq("dbus_keep", CPU_dcrDBusOut,   exp_dbus);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_strobes"}, 32'({CPU_dcrRead, CPU_dcrWrite}), 32'd0);
        check_eq({tag, "_abus"},    32'(CPU_dcrABus),                 32'd0);
        check_eq({tag, "_dbus"},    CPU_dcrDBusOut,                   32'd0);
        check_eq({tag, "_rddata"},  dcrRdData,                        32'd0);
        check_eq({tag, "_flags"},   32'({dcrHold, dcrDone, dcrTimeout, dcrErr}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rr;
        logic [9:0] ra;
        resetCore      = 1'b1;
        exeDcrRdReq    = 1'b0;
        exeDcrWrReq    = 1'b0;
        EXE_dcrAddr    = '0;
        EXE_dcrDataBus = '0;
        DCR_cpuAck     = 1'b0;
        DCR_cpuDBusIn  = '0;
        repeat (3) tick();
        check_all_zero("reset");
        resetCore = 1'b0;
        repeat (2) tick();

        // Read, ack 3 cycles after strobe for 2 cycles
        do_access(1, 0, 10'h0A5, 32'h0, 32'hDEADBEEF, 1, 3, 2);
        // Write, single-cycle ack
        do_access(0, 1, 10'h3FF, 32'h12345678, 32'h0, 1, 1, 1);
        // Read timeout with no ack
        do_access(1, 0, 10'h155, 32'h0, 32'h11112222, 0, 0, 0);
        // Read timeout followed by a late ack pulse
        do_access(1, 0, 10'h2AA, 32'h0, 32'h33334444, 1, 8, 2);
        // Write after the late ack completes normally
        do_access(0, 1, 10'h001, 32'hA5A55A5A, 32'h0, 1, 2, 1);
        // Illegal simultaneous request
        do_access(1, 1, 10'h077, 32'hFFFF0000, 32'h0, 0, 0, 0);

        // Reset during the second XFER cycle of a write
        exeDcrWrReq    = 1'b1;
        EXE_dcrAddr    = 10'h0F0;
        EXE_dcrDataBus = 32'h55AA55AA;
        tick();
        check_eq("rst_wr_strobe", 32'(CPU_dcrWrite), 32'd1);
        tick();
        resetCore   = 1'b1;
        exeDcrWrReq = 1'b0;
        tick();
        check_all_zero("midrst");
        resetCore = 1'b0;
        exp_rdata = '0;
        exp_dbus  = '0;
        exp_abus  = '0;
        repeat (3) tick();

        // Minimum-latency read after reset
        do_access(1, 0, 10'h2C3, 32'h0, 32'hCAFEF00D, 1, 0, 1);

        // A few random accesses
        for (int i = 0; i < 4; i++) begin
            rr = 1'($urandom_range(0, 1));
            ra = 10'($urandom_range(0, 1023));
            do_access(rr, !rr, ra, $urandom, $urandom, 1,
                      int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
        end

        repeat (4) tick();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_p405s_dcr_access_ctl
